// File: rtl/gb_lcd_capture.sv
// Game Boy PPU pixel capture into a double-buffered 160x144 framebuffer.
// Tracks line/frame position, generates write addresses incrementally and flags malformed frames.
module gb_lcd_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        lcd_on,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pix_valid,
  input  logic [1:0]  pix_data,
  input  logic        clr_err,
  output logic        fb_we,
  output logic [15:0] fb_waddr,
  output logic [1:0]  fb_wdata,
  output logic        rd_bank,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        err_overrun,
  output logic        err_short
);

  typedef enum logic [1:0] {IDLE, LINE, WAIT_LINE} state_e;

  localparam logic [7:0]  X_LAST    = 8'(H_PIXELS - 1);
  localparam logic [7:0]  Y_LAST    = 8'(V_LINES - 1);
  localparam logic [14:0] LINE_STEP = 15'(H_PIXELS);

  state_e      state_q;
  logic [7:0]  x_q, y_q;
  logic [14:0] offset_q, line_base_q;
  logic        wr_bank_q;
  logic [7:0]  frame_count_q;
  logic        err_overrun_q, err_short_q;
  logic        fb_we_q, frame_done_q;
  logic [15:0] fb_waddr_q;
  logic [1:0]  fb_wdata_q;

  // Position of the pixel slot for this cycle, after any frame/line pulse is applied.
  logic [7:0]  cur_x_d, y_d;
  logic [14:0] cur_off_d, line_base_d;
  logic        open_d, abort_d, short_d, overrun_d, accept_d, frame_end_d, bank_d;

  always_comb begin
    // NOTE: every signal gets a default before the branches, so no latch can be inferred.
    open_d      = (state_q == LINE);
    abort_d     = 1'b0;
    short_d     = 1'b0;
    overrun_d   = 1'b0;
    cur_x_d     = x_q;
    y_d         = y_q;
    cur_off_d   = offset_q;
    line_base_d = line_base_q;

    if (lcd_on) begin
      if (frame_start) begin
        open_d      = 1'b1;
        cur_x_d     = '0;
        y_d         = '0;
        cur_off_d   = '0;
        line_base_d = '0;
        short_d     = (state_q != IDLE);
      end else if (line_start && state_q != IDLE) begin
        short_d = (state_q == LINE);
        if (y_q == Y_LAST) begin
          // Early end of the last line: the frame is abandoned without a swap.
          open_d  = 1'b0;
          abort_d = 1'b1;
        end else begin
          open_d      = 1'b1;
          cur_x_d     = '0;
          y_d         = y_q + 8'd1;
          cur_off_d   = line_base_q + LINE_STEP;
          line_base_d = line_base_q + LINE_STEP;
        end
      end else if (state_q == WAIT_LINE && pix_valid) begin
        overrun_d = 1'b1;
      end
    end

    accept_d    = lcd_on && open_d && pix_valid;
    frame_end_d = accept_d && (cur_x_d == X_LAST) && (y_d == Y_LAST);
    // The bank flips the edge after frame_done; a pixel accepted on that edge already uses the new bank.
    bank_d      = wr_bank_q ^ frame_done_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      offset_q      <= '0;
      line_base_q   <= '0;
      wr_bank_q     <= 1'b0;
      frame_count_q <= '0;
      err_overrun_q <= 1'b0;
      err_short_q   <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_waddr_q    <= '0;
      fb_wdata_q    <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_bank_q    <= bank_d;
      if (frame_done_q) frame_count_q <= frame_count_q + 8'd1;

      err_overrun_q <= overrun_d | (err_overrun_q & ~clr_err);
      err_short_q   <= short_d   | (err_short_q   & ~clr_err);

      if (!lcd_on) begin
        state_q <= IDLE;
      end else if (open_d) begin
        state_q     <= LINE;
        x_q         <= cur_x_d;
        y_q         <= y_d;
        offset_q    <= cur_off_d;
        line_base_q <= line_base_d;
        if (accept_d) begin
          fb_we_q    <= 1'b1;
          fb_waddr_q <= {bank_d, cur_off_d};
          fb_wdata_q <= pix_data;
          x_q        <= cur_x_d + 8'd1;
          offset_q   <= cur_off_d + 15'd1;
          if (cur_x_d == X_LAST) begin
            state_q      <= frame_end_d ? IDLE : WAIT_LINE;
            frame_done_q <= frame_end_d;
          end
        end
      end else if (abort_d) begin
        state_q <= IDLE;
      end
    end
  end

  assign fb_we       = fb_we_q;
  assign fb_waddr    = fb_waddr_q;
  assign fb_wdata    = fb_wdata_q;
  assign rd_bank     = ~wr_bank_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_overrun = err_overrun_q;
  assign err_short   = err_short_q;

endmodule

// File: doc/gb_lcd_capture.md
# gb_lcd_capture

Captures the Game Boy PPU pixel stream (160x144, 2-bit shade) and writes it into a double-buffered framebuffer RAM that the HDMI scan-out side reads. Sits directly downstream of the PPU inside `top_level` and upstream of the framebuffer BRAM and HDMI video path. It tracks line/frame position, generates write addresses incrementally, swaps banks on each completed frame, and flags malformed frames.

## Interface
- `H_PIXELS`, default 160, pixels per line
- `V_LINES`, default 144, visible lines per frame
- `Clk`  input  1  system clock; all logic on rising edge
- `Reset`  input  1  synchronous, active-high reset
- `lcd_on`  input  1  LCDC bit 7; low forces IDLE
- `frame_start`  input  1  one-cycle pulse at start of line 0
- `line_start`  input  1  one-cycle pulse at start of lines 1..143
- `pix_valid`  input  1  pixel present on `pix_data` this cycle
- `pix_data`  input  2  shade index 0..3
- `clr_err`  input  1  clears sticky error flags
- `fb_we`  output  1  framebuffer write enable
- `fb_waddr`  output  16  {wr_bank, 15-bit offset}; offset = y*160 + x
- `fb_wdata`  output  2  shade written
- `rd_bank`  output  1  bank HDMI side reads; always ~wr_bank
- `frame_done`  output  1  one-cycle pulse on final pixel write of a complete frame
- `frame_count`  output  8  completed frames, wraps 255->0
- `err_overrun`  output  1  sticky: pixel received with no line open
- `err_short`  output  1  sticky: line or frame ended early

## Operation
- States: IDLE (await `frame_start`), LINE (accepting pixels, x<160), WAIT_LINE (160 pixels taken, await `line_start`).
- Counters: x 0..159, y 0..143, offset 0..23039; `line_base` register advances by 160 per line (no multiplier).
- IDLE: `frame_start` -> LINE, x=0, y=0, offset=0. Pixels and `line_start` in IDLE ignored (no error).
- LINE: each `pix_valid` writes `pix_data` at current offset, x++, offset++. On x reaching 160: if y==143 -> frame complete (frame_done, swap, frame_count++) -> IDLE; else -> WAIT_LINE.
- WAIT_LINE: `line_start` -> LINE, y++, x=0, offset=line_base+160. `pix_valid` here is dropped, sets `err_overrun`.
- `line_start` in LINE with x<160: sets `err_short`, advances to next line as above; unwritten pixels keep old contents. If y==143, treat as early frame end: set `err_short`, go IDLE, no swap.
- `frame_start` in LINE/WAIT_LINE: sets `err_short`, restarts at y=0,x=0 in the same bank, no swap.
- Same-cycle pixel with `frame_start`/`line_start`: the pulse takes effect first; the pixel is x=0 of the new line and written.
- `lcd_on`=0: go IDLE immediately, cancel any pending write beyond the current cycle, no swap, no error.
- `clr_err` clears both flags; an error event in the same cycle wins (flag stays set).

## Timing
- Reset values: state IDLE, `fb_we`=0, `fb_waddr`=0, `fb_wdata`=0, wr_bank=0, `rd_bank`=1, `frame_done`=0, `frame_count`=0, both errors 0.
- `fb_we`/`fb_waddr`/`fb_wdata` registered: asserted one cycle after the accepting `pix_valid` edge; one write per pixel, back-to-back pixels every cycle supported.
- `frame_done` asserted in the same cycle as the final `fb_we` (offset 23039, old bank). wr_bank/`rd_bank` toggle and `frame_count` increments on the following edge.
- Error flags set on the edge after the offending event.
- Reset mid-frame: all state returns to reset values on that edge; no write issued the next cycle.

## Test plan
- Full frame, 160 pixels per line, `line_start` between lines -> 23040 writes, offsets 0..23039 in bank 0, `frame_done` once, then `rd_bank`=0, `frame_count`=1, no errors.
- Two full frames -> second frame writes bank 1 (`fb_waddr`=0x8000..0xD9FF), `rd_bank` returns to 1, `frame_count`=2.
- Line 5 given only 100 pixels then `line_start` -> `err_short`=1, line 6 first write offset 960.
- Extra 161st pixel on line 0 -> not written, `err_overrun`=1; `clr_err` -> both flags 0.
- `frame_start` at line 70 -> `err_short`=1, next write offset 0 same bank, no bank swap, `frame_count` unchanged.
- `lcd_on` dropped mid-line 10, then Reset asserted mid-frame -> no further writes, outputs at reset values, `frame_count`=0.
